// File: rtl/pacman_video_pkg.sv
// pacman_video_pkg: maze RAM geometry, arbiter owner states and the buffered game-logic op record.
package pacman_video_pkg;
  localparam int IMG_W = 224;
  localparam int IMG_H = 288;
  localparam int MEM_DEPTH = IMG_W * IMG_H;
  localparam int VRAM_ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, SCAN, GL_RD} owner_t;
  typedef struct packed {
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [3:0]             wdata;
  } op_t;
endpackage

// File: rtl/vram_op_fifo.sv
// vram_op_fifo: in-order sync FIFO holding game-logic RAM ops until a free issue slot.
module vram_op_fifo import pacman_video_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  op_t                      din,
  output op_t                      dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  op_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the maze RAM between VGA scan-out (always wins) and FIFO-buffered game-logic ops.
module vram_arbiter import pacman_video_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int MEM_DEPTH = pacman_video_pkg::MEM_DEPTH
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [3:0]        scan_data,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [3:0]        gl_wdata,
  output logic              gl_ready,
  output logic              gl_rvalid,
  output logic [3:0]        gl_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wdata,
  input  logic [3:0]        mem_rdata,
  output logic              err_oob,
  output logic [15:0]       stall_cnt
);
  owner_t owner_q, owner_d;
  op_t head;
  logic rdy_q, rd_oob_q, rd_oob_d, err_q, err_d;
  logic full, empty, push, pop, oob;
  logic [15:0] stall_q, stall_d;
  logic [$clog2(FIFO_DEPTH):0] cnt;
  assign push = gl_req && gl_ready;
  vram_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .pclk(pclk), .rst(rst), .push(push), .pop(pop),
    .din('{we: gl_we, addr: gl_addr, wdata: gl_wdata}),
    .dout(head), .full(full), .empty(empty), .count(cnt)
  );
  // rd_oob_q marks an in-flight out-of-range read so its data is forced to 0
  always_comb begin
    pop = !scan_req && !empty;
    oob = 32'(head.addr) >= 32'(MEM_DEPTH);
    mem_addr = scan_req ? scan_addr : (pop ? head.addr : '0);
    mem_we = pop && head.we && !oob;
    mem_wdata = mem_we ? head.wdata : '0;
    owner_d = scan_req ? SCAN : ((pop && !head.we) ? GL_RD : IDLE);
    rd_oob_d = pop && oob;
    err_d = err_q || (pop && oob);
    stall_d = (scan_req && cnt != '0 && stall_q != '1) ? stall_q + 16'd1 : stall_q;
    gl_ready = rdy_q && !full;
    gl_rvalid = owner_q == GL_RD;
    gl_rdata = (gl_rvalid && !rd_oob_q) ? mem_rdata : '0;
    scan_data = (owner_q == SCAN) ? mem_rdata : '0;
    err_oob = err_q;
    stall_cnt = stall_q;
  end
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      owner_q <= IDLE;
      rdy_q <= 1'b0;
      rd_oob_q <= 1'b0;
      err_q <= 1'b0;
      stall_q <= '0;
    end else begin
      owner_q <= owner_d;
      rdy_q <= 1'b1;
      rd_oob_q <= rd_oob_d;
      err_q <= err_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table plus hand sequences and random traffic against a RAM model.
module tb_vram_arbiter;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic scan_req = 1'b0, gl_req = 1'b0, gl_we = 1'b0;
  logic [15:0] scan_addr = '0, gl_addr = '0;
  logic [3:0] gl_wdata = '0;
  logic [3:0] scan_data, gl_rdata, mem_wdata;
  logic [3:0] mem_rdata = '0;
  logic gl_ready, gl_rvalid, mem_we, err_oob;
  logic [15:0] mem_addr, stall_cnt;
  int chk_cnt = 0;
  int pass_cnt = 0;

  vram_arbiter dut (
    .pclk(pclk), .rst(rst), .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data),
    .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata), .gl_ready(gl_ready),
    .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_oob(err_oob), .stall_cnt(stall_cnt)
  );

  always #5 pclk = ~pclk;

  // RAM model: unwritten words read back as the low nibble of their address
  logic [3:0] ram [65536];
  bit written [65536];
  always @(posedge pclk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? ram[mem_addr] : mem_addr[3:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    scan_req = 1'b0; scan_addr = '0; gl_req = 1'b0; gl_we = 1'b0; gl_addr = '0; gl_wdata = '0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge pclk); #1;
    rst = 1'b1;
    idle_inputs();
    @(negedge pclk);
    chk({tag, "_rst_ready"}, gl_ready, 0);
    chk({tag, "_rst_rvalid"}, gl_rvalid, 0);
    chk({tag, "_rst_err"}, err_oob, 0);
    chk({tag, "_rst_stall"}, stall_cnt, 0);
    chk({tag, "_rst_memwe"}, mem_we, 0);
    @(posedge pclk); #1;
    rst = 1'b0;
    @(negedge pclk);
    chk({tag, "_ready_low_release"}, gl_ready, 0);
  endtask

  typedef struct {
    logic sreq; logic [15:0] saddr;
    logic greq; logic gwe; logic [15:0] gaddr; logic [3:0] gwd;
    logic rdy; logic we; logic [15:0] addr; logic rv; logic [3:0] rd; logic [3:0] sd; logic err;
  } vec_t;

  vec_t v [16];
  logic [3:0] refm [64];
  logic [3:0] expq [$];

  initial begin
    // sreq saddr greq gwe gaddr gwd | rdy we addr rv rd sd err
    v[0]  = '{0, 16'd0,   1, 1, 16'h0023, 4'hC,  1, 0, 16'h0000, 0, 4'h0, 4'h0, 0};
    v[1]  = '{0, 16'd0,   1, 0, 16'h0023, 4'h0,  1, 1, 16'h0023, 0, 4'h0, 4'h0, 0};
    v[2]  = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0023, 0, 4'h0, 4'h0, 0};
    v[3]  = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0000, 1, 4'hC, 4'h0, 0};
    v[4]  = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0000, 0, 4'h0, 4'h0, 0};
    v[5]  = '{1, 16'd100, 1, 0, 16'd200,  4'h0,  1, 0, 16'd100,  0, 4'h0, 4'h0, 0};
    v[6]  = '{1, 16'd100, 0, 0, 16'h0000, 4'h0,  1, 0, 16'd100,  0, 4'h0, 4'h4, 0};
    v[7]  = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'd200,  0, 4'h0, 4'h4, 0};
    v[8]  = '{1, 16'd100, 0, 0, 16'h0000, 4'h0,  1, 0, 16'd100,  1, 4'h8, 4'h0, 0};
    v[9]  = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0000, 0, 4'h0, 4'h4, 0};
    v[10] = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0000, 0, 4'h0, 4'h0, 0};
    v[11] = '{0, 16'd0,   1, 1, 16'hFC00, 4'hF,  1, 0, 16'h0000, 0, 4'h0, 4'h0, 0};
    v[12] = '{0, 16'd0,   1, 0, 16'hFFFF, 4'h0,  1, 0, 16'hFC00, 0, 4'h0, 4'h0, 0};
    v[13] = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'hFFFF, 0, 4'h0, 4'h0, 1};
    v[14] = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0000, 1, 4'h0, 4'h0, 1};
    v[15] = '{0, 16'd0,   0, 0, 16'h0000, 4'h0,  1, 0, 16'h0000, 0, 4'h0, 4'h0, 1};

    idle_inputs();
    repeat (2) @(posedge pclk);
    do_reset("init");

    for (int i = 0; i < 16; i++) begin
      @(posedge pclk); #1;
      scan_req = v[i].sreq; scan_addr = v[i].saddr;
      gl_req = v[i].greq; gl_we = v[i].gwe; gl_addr = v[i].gaddr; gl_wdata = v[i].gwd;
      @(negedge pclk);
      chk($sformatf("v%0d_ready", i), gl_ready, v[i].rdy);
      chk($sformatf("v%0d_mem_we", i), mem_we, v[i].we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].addr);
      chk($sformatf("v%0d_rvalid", i), gl_rvalid, v[i].rv);
      chk($sformatf("v%0d_rdata", i), gl_rdata, v[i].rd);
      chk($sformatf("v%0d_scan_data", i), scan_data, v[i].sd);
      chk($sformatf("v%0d_err_oob", i), err_oob, v[i].err);
      if (i == 1) chk("v1_mem_wdata", mem_wdata, 4'hC);
    end
    chk("table_stall_cnt", stall_cnt, 1);

    // scan holds the port for a full line while four writes queue up
    do_reset("t2");
    begin
      int we_seen = 0;
      for (int i = 0; i < 224; i++) begin
        @(posedge pclk); #1;
        scan_req = 1'b1; scan_addr = 16'(i);
        gl_req = (i < 4); gl_we = 1'b1; gl_addr = 16'h10 + 16'(i); gl_wdata = 4'h9 + 4'(i);
        @(negedge pclk);
        if (i == 3) chk("t2_ready_before_full", gl_ready, 1);
        if (i == 4) chk("t2_ready_full", gl_ready, 0);
        if (mem_we) we_seen++;
      end
      chk("t2_no_we_during_scan", we_seen, 0);
    end
    for (int j = 0; j < 5; j++) begin
      @(posedge pclk); #1;
      idle_inputs();
      @(negedge pclk);
      if (j == 0) chk("t2_stall_cnt", stall_cnt, 223);
      if (j == 0) chk("t2_ready_still_full", gl_ready, 0);
      if (j == 1) chk("t2_ready_after_pop", gl_ready, 1);
      chk($sformatf("t2_we_%0d", j), mem_we, j < 4);
      if (j < 4) begin
        chk($sformatf("t2_addr_%0d", j), mem_addr, 16'h10 + 16'(j));
        chk($sformatf("t2_wdata_%0d", j), mem_wdata, 4'h9 + 4'(j));
      end
    end

    // reset lands while the second of three reads is in flight
    do_reset("t5");
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      gl_req = 1'b1; gl_we = 1'b0; gl_addr = 16'(k + 1);
      @(negedge pclk);
      if (k == 2) begin
        chk("t5_first_rvalid", gl_rvalid, 1);
        chk("t5_first_rdata", gl_rdata, 4'h1);
      end
    end
    @(posedge pclk); #1;
    rst = 1'b1;
    idle_inputs();
    @(negedge pclk);
    chk("t5_inflight_dropped", gl_rvalid, 0);
    chk("t5_ready_in_rst", gl_ready, 0);
    @(posedge pclk); #1;
    rst = 1'b0;
    @(negedge pclk);
    chk("t5_rvalid_release", gl_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (k == 0) chk("t5_ready_after_rst", gl_ready, 1);
      chk($sformatf("t5_no_rvalid_%0d", k), gl_rvalid, 0);
      chk($sformatf("t5_fifo_empty_%0d", k), mem_addr, 0);
    end

    // random game traffic against 800-cycle lines with a 224-cycle scan window
    do_reset("t6");
    for (int i = 0; i < 64; i++) refm[i] = 4'(i);
    expq.delete();
    begin
      logic prev_s = 1'b0;
      logic [15:0] prev_a = '0;
      for (int c = 0; c < 15 * 800 + 12; c++) begin
        int x = c % 800;
        @(posedge pclk); #1;
        scan_req = (c < 15 * 800) && (x < 224);
        scan_addr = scan_req ? 16'h1000 + 16'((c / 800) * 224 + x) : '0;
        gl_req = (c < 15 * 800) ? 1'($urandom_range(0, 1)) : 1'b0;
        gl_we = 1'($urandom_range(0, 1));
        gl_addr = 16'h100 + 16'($urandom_range(0, 63));
        gl_wdata = 4'($urandom);
        @(negedge pclk);
        if (gl_req && gl_ready) begin
          if (gl_we) refm[gl_addr[5:0]] = gl_wdata;
          else expq.push_back(refm[gl_addr[5:0]]);
        end
        if (gl_rvalid) begin
          if (expq.size() == 0) chk("t6_unexpected_rvalid", 1, 0);
          else chk($sformatf("t6_rdata_c%0d", c), gl_rdata, expq.pop_front());
        end
        chk($sformatf("t6_scan_c%0d", c), scan_data, prev_s ? prev_a[3:0] : 4'h0);
        prev_s = scan_req;
        prev_a = scan_addr;
      end
    end
    chk("t6_all_reads_returned", expq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
